// File: rtl/dmem_ctrl.sv
// Data-memory interface stage: aligns core loads/stores onto a
// word-organised byte-enabled memory with req/ack and timeout.
module dmem_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [2:0]  core_funct3,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  output logic        core_misalign,
  output logic        core_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;

  logic        legal;
  logic        misal;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ext;
  logic        stall_c;
  logic        misal_c;

  always_comb begin
    legal = 1'b0;
    case (core_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !core_we;
      default:                legal = 1'b0;
    endcase
  end

  // Only legal accesses can be misaligned; bad funct3 takes the error path.
  assign misal = legal &
    (((core_funct3[1:0] == 2'b01) & core_addr[0]) |
     ((core_funct3[1:0] == 2'b10) & (|core_addr[1:0])));

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = core_wdata;
    unique case (1'b1)
      core_funct3[1:0] == 2'b00: begin
        be_n    = 4'b0001 << core_addr[1:0];
        wdata_n = {4{core_wdata[7:0]}};
      end
      core_funct3[1:0] == 2'b01: begin
        be_n    = 4'b0011 << core_addr[1:0];
        wdata_n = {2{core_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lb  = mem_rdata[{off_q, 3'b000} +: 8];
    lh  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ext = mem_rdata;
    case (f3_q)
      3'b000:  ext = {{24{lb[7]}}, lb};
      3'b001:  ext = {{16{lh[15]}}, lh};
      3'b100:  ext = {24'b0, lb};
      3'b101:  ext = {16'b0, lh};
      default: ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    f3_d        = f3_q;
    off_d       = off_q;
    stall_c     = 1'b0;
    misal_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (core_req) begin
          if (misal) begin
            misal_c = 1'b1;
          end else if (!legal) begin
            stall_c = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = DONE;
          end else begin
            stall_c     = 1'b1;
            mem_req_d   = 1'b1;
            mem_we_d    = core_we;
            mem_be_d    = be_n;
            mem_addr_d  = {core_addr[31:2], 2'b00};
            mem_wdata_d = wdata_n;
            f3_d        = core_funct3;
            off_d       = core_addr[1:0];
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        stall_c = 1'b1;
        if (mem_ack) begin
          rdata_d   = mem_we_q ? 32'h0 : ext;
          err_d     = 1'b0;
          mem_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = DONE;
        end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
    end
  end

  // Combinational flags are forced low while reset is held.
  assign core_stall    = rst & stall_c;
  assign core_misalign = rst & misal_c;
  assign core_rdata    = rdata_q;
  assign core_err      = err_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_be        = mem_be_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;

endmodule
